// File: rtl/axi_rab_pkg.sv
// Shared RAB datapath definitions: R-channel beat field layout and width helper.
package axi_rab_pkg;

    localparam int unsigned R_RESP_LSB = 0;
    localparam int unsigned R_LAST_BIT = 2;
    localparam int unsigned R_ID_LSB   = 3;

    // Packed R beat is {ruser, rdata, rid, rlast, rresp}
    function automatic int unsigned r_beat_width(input int unsigned id_w,
                                                 input int unsigned data_w,
                                                 input int unsigned user_w);
        return id_w + data_w + user_w + 3;
    endfunction

endpackage

// File: rtl/axi_fifo_rab.sv
// Generic power-of-two FIFO with wrap-bit pointers, full/empty and occupancy.
module axi_fifo_rab #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 4,
    localparam int unsigned AW        = $clog2(DEPTH),
    localparam int unsigned PW        = AW + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  full,
    output logic                  empty,
    output logic [PW-1:0]         occupancy
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign empty = (wr_ptr == rd_ptr);

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Wrap-bit difference yields 0..DEPTH without a separate counter
    assign occupancy = wr_ptr - rd_ptr;
    assign rdata     = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/axi4_r_buffer_sf.sv
// AXI4 R-channel buffer with configurable depth and optional per-burst store-and-forward.
module axi4_r_buffer_sf
    import axi_rab_pkg::*;
#(
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned AXI_ID_WIDTH   = 4,
    parameter int unsigned AXI_USER_WIDTH = 4,
    parameter int unsigned DEPTH          = 4,
    parameter int unsigned STORE_FWD      = 0
) (
    input  logic                      axi4_aclk,
    input  logic                      axi4_arstn,
    input  logic [AXI_ID_WIDTH-1:0]   m_axi4_rid,
    input  logic [AXI_DATA_WIDTH-1:0] m_axi4_rdata,
    input  logic [1:0]                m_axi4_rresp,
    input  logic                      m_axi4_rlast,
    input  logic [AXI_USER_WIDTH-1:0] m_axi4_ruser,
    input  logic                      m_axi4_rvalid,
    output logic                      m_axi4_rready,
    output logic [AXI_ID_WIDTH-1:0]   s_axi4_rid,
    output logic [AXI_DATA_WIDTH-1:0] s_axi4_rdata,
    output logic [1:0]                s_axi4_rresp,
    output logic                      s_axi4_rlast,
    output logic [AXI_USER_WIDTH-1:0] s_axi4_ruser,
    output logic                      s_axi4_rvalid,
    input  logic                      s_axi4_rready,
    output logic [$clog2(DEPTH):0]    occupancy,
    output logic [$clog2(DEPTH):0]    burst_cnt
);

    localparam int unsigned BW        = r_beat_width(AXI_ID_WIDTH, AXI_DATA_WIDTH, AXI_USER_WIDTH);
    localparam int unsigned CW        = $clog2(DEPTH) + 1;
    localparam int unsigned R_DATA_LSB = R_ID_LSB + AXI_ID_WIDTH;
    localparam int unsigned R_USER_LSB = R_DATA_LSB + AXI_DATA_WIDTH;

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("axi4_r_buffer_sf: DEPTH must be a power of two and at least 2");
        end
    endgenerate

    logic [BW-1:0] beat_in;
    logic [BW-1:0] beat_head;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          rdy_en_q;
    logic          fwd_q;

    assign beat_in = {m_axi4_ruser, m_axi4_rdata, m_axi4_rid, m_axi4_rlast, m_axi4_rresp};

    assign s_axi4_rresp = beat_head[R_RESP_LSB +: 2];
    assign s_axi4_rlast = beat_head[R_LAST_BIT];
    assign s_axi4_rid   = beat_head[R_ID_LSB +: AXI_ID_WIDTH];
    assign s_axi4_rdata = beat_head[R_DATA_LSB +: AXI_DATA_WIDTH];
    assign s_axi4_ruser = beat_head[R_USER_LSB +: AXI_USER_WIDTH];

    // Ready depends only on registered state, never on the upstream ready
    assign m_axi4_rready = rdy_en_q & ~full;
    assign push          = m_axi4_rvalid & m_axi4_rready;
    assign pop           = s_axi4_rvalid & s_axi4_rready;

    // A full buffer with no complete burst must forward, or the slave could never finish the burst
    assign s_axi4_rvalid = (STORE_FWD != 0)
                         ? (~empty & ((burst_cnt != '0) | full | fwd_q))
                         : ~empty;

    axi_fifo_rab #(
        .DATA_WIDTH (BW),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk       (axi4_aclk),
        .rst_n     (axi4_arstn),
        .push      (push),
        .wdata     (beat_in),
        .pop       (pop),
        .rdata     (beat_head),
        .full      (full),
        .empty     (empty),
        .occupancy (occupancy)
    );

    always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
        if (!axi4_arstn) begin
            rdy_en_q  <= 1'b0;
            fwd_q     <= 1'b0;
            burst_cnt <= '0;
        end else begin
            rdy_en_q <= 1'b1;
            case ({push & m_axi4_rlast, pop & s_axi4_rlast})
                2'b10:   burst_cnt <= burst_cnt + CW'(1);
                2'b01:   burst_cnt <= burst_cnt - CW'(1);
                default: burst_cnt <= burst_cnt;
            endcase
            if (STORE_FWD != 0) begin
                if (full && burst_cnt == '0) fwd_q <= 1'b1;
                else if (pop && s_axi4_rlast) fwd_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axi4_r_buffer_sf.sv
// Directed bench for axi4_r_buffer_sf across cut-through and store-and-forward configurations.
module tb_axi4_r_buffer_sf;

    localparam int N = 5;
    localparam int unsigned DEP [N] = '{4, 4, 8, 2, 16};
    localparam int unsigned SFW [N] = '{0, 1, 1, 0, 0};

    logic        clk;
    logic        rst_n;
    logic [3:0]  m_rid    [N];
    logic [31:0] m_rdata  [N];
    logic [1:0]  m_rresp  [N];
    logic        m_rlast  [N];
    logic [3:0]  m_ruser  [N];
    logic        m_rvalid [N];
    logic        m_rready [N];
    logic [3:0]  s_rid    [N];
    logic [31:0] s_rdata  [N];
    logic [1:0]  s_rresp  [N];
    logic        s_rlast  [N];
    logic [3:0]  s_ruser  [N];
    logic        s_rvalid [N];
    logic        s_rready [N];
    logic [4:0]  occ      [N];
    logic [4:0]  bcnt     [N];

    int n_checks = 0;
    int n_fails  = 0;
    int pops [N];
    logic [63:0] exp_q [N][$];
    logic        prv_v   [N];
    logic        prv_pop [N];
    logic [63:0] prv_d   [N];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int CW = $clog2(DEP[g]) + 1;
        logic [CW-1:0] occ_w;
        logic [CW-1:0] bc_w;
        assign occ[g]  = 5'(occ_w);
        assign bcnt[g] = 5'(bc_w);
        axi4_r_buffer_sf #(
            .AXI_DATA_WIDTH (32),
            .AXI_ID_WIDTH   (4),
            .AXI_USER_WIDTH (4),
            .DEPTH          (DEP[g]),
            .STORE_FWD      (SFW[g])
        ) u_dut (
            .axi4_aclk     (clk),
            .axi4_arstn    (rst_n),
            .m_axi4_rid    (m_rid[g]),
            .m_axi4_rdata  (m_rdata[g]),
            .m_axi4_rresp  (m_rresp[g]),
            .m_axi4_rlast  (m_rlast[g]),
            .m_axi4_ruser  (m_ruser[g]),
            .m_axi4_rvalid (m_rvalid[g]),
            .m_axi4_rready (m_rready[g]),
            .s_axi4_rid    (s_rid[g]),
            .s_axi4_rdata  (s_rdata[g]),
            .s_axi4_rresp  (s_rresp[g]),
            .s_axi4_rlast  (s_rlast[g]),
            .s_axi4_ruser  (s_ruser[g]),
            .s_axi4_rvalid (s_rvalid[g]),
            .s_axi4_rready (s_rready[g]),
            .occupancy     (occ_w),
            .burst_cnt     (bc_w)
        );
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] mk(input logic [3:0] id, input logic [31:0] d,
                                       input logic [1:0] r, input logic l, input logic [3:0] u);
        return {21'd0, u, id, d, r, l};
    endfunction

    function automatic logic [63:0] in_beat(input int i);
        return mk(m_rid[i], m_rdata[i], m_rresp[i], m_rlast[i], m_ruser[i]);
    endfunction

    function automatic logic [63:0] out_beat(input int i);
        return mk(s_rid[i], s_rdata[i], s_rresp[i], s_rlast[i], s_ruser[i]);
    endfunction

    task automatic put(input int i, input logic v, input logic [63:0] b);
        m_rvalid[i] = v;
        m_rlast[i]  = b[0];
        m_rresp[i]  = b[2:1];
        m_rdata[i]  = b[34:3];
        m_rid[i]    = b[38:35];
        m_ruser[i]  = b[42:39];
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Hold one beat valid until accepted, bounded
    task automatic push_one(input int i, input logic [63:0] b);
        logic acc;
        acc = 1'b0;
        put(i, 1'b1, b);
        for (int k = 0; k < 50 && !acc; k++) begin
            acc = m_rready[i];
            cyc();
        end
        put(i, 1'b0, 64'd0);
        check("push_accepted", 64'(acc), 64'd1);
    endtask

    task automatic wait_drain(input int i);
        for (int k = 0; k < 50 && occ[i] != 5'd0; k++) cyc();
        check("drain_occ", 64'(occ[i]), 64'd0);
    endtask

    task automatic run_random(input int i, input int n);
        int   base;
        int   sent;
        int   cycles;
        int   max_occ;
        logic acc;
        base    = pops[i];
        sent    = 0;
        cycles  = 0;
        max_occ = 0;
        while ((pops[i] - base) < n && cycles < 4000) begin
            acc = m_rvalid[i] & m_rready[i];
            cyc();
            cycles++;
            if (acc) sent++;
            if (int'(occ[i]) > max_occ) max_occ = int'(occ[i]);
            if (!m_rvalid[i] || acc) begin
                if (sent < n && $urandom_range(0, 3) != 0)
                    put(i, 1'b1, mk(4'($urandom), $urandom, 2'($urandom),
                                    (sent == n - 1) || ($urandom_range(0, 3) == 0), 4'($urandom)));
                else
                    put(i, 1'b0, 64'd0);
            end
            s_rready[i] = ($urandom_range(0, 2) != 0);
        end
        put(i, 1'b0, 64'd0);
        s_rready[i] = 1'b0;
        cyc();
        check("rnd_pops", 64'(pops[i] - base), 64'(n));
        check("rnd_max_occ_ok", 64'(max_occ <= int'(DEP[i])), 64'd1);
        check("rnd_occ_end", 64'(occ[i]), 64'd0);
        check("rnd_bcnt_end", 64'(bcnt[i]), 64'd0);
    endtask

    // Scoreboard, payload-stability and order checks sampled mid-cycle
    always @(negedge clk) begin
        logic [63:0] o;
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                exp_q[i].delete();
                prv_v[i] = 1'b0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                o = out_beat(i);
                if (prv_v[i] && !prv_pop[i]) begin
                    check("stable_valid", 64'(s_rvalid[i]), 64'd1);
                    check("stable_payload", o, prv_d[i]);
                end
                if (s_rvalid[i] && s_rready[i]) begin
                    if (exp_q[i].size() == 0) check("pop_unexpected", 64'(s_rvalid[i]), 64'd0);
                    else check("order", o, exp_q[i].pop_front());
                    pops[i]++;
                end
                if (m_rvalid[i] && m_rready[i]) exp_q[i].push_back(in_beat(i));
                prv_v[i]   = s_rvalid[i];
                prv_pop[i] = s_rready[i];
                prv_d[i]   = o;
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) begin
            put(i, 1'b0, 64'd0);
            s_rready[i] = 1'b0;
            pops[i]     = 0;
            prv_v[i]    = 1'b0;
            prv_pop[i]  = 1'b0;
            prv_d[i]    = 64'd0;
        end
        #1;
        check("rst_s_valid", 64'(s_rvalid[0]), 64'd0);
        check("rst_m_ready", 64'(m_rready[0]), 64'd0);
        check("rst_occ", 64'(occ[0]), 64'd0);
        check("rst_bcnt", 64'(bcnt[0]), 64'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        #1 check("rel_m_ready_low", 64'(m_rready[0]), 64'd0);
        cyc();
        check("rel_m_ready_high", 64'(m_rready[0]), 64'd1);

        // 1: single beat, visible the cycle after push
        put(0, 1'b1, mk(4'd3, 32'hA5A5_A5A5, 2'd0, 1'b1, 4'd0));
        cyc();
        put(0, 1'b0, 64'd0);
        check("t1_valid", 64'(s_rvalid[0]), 64'd1);
        check("t1_rid", 64'(s_rid[0]), 64'd3);
        check("t1_rdata", 64'(s_rdata[0]), 64'hA5A5_A5A5);
        check("t1_rresp", 64'(s_rresp[0]), 64'd0);
        check("t1_rlast", 64'(s_rlast[0]), 64'd1);
        check("t1_occ", 64'(occ[0]), 64'd1);
        check("t1_bcnt", 64'(bcnt[0]), 64'd1);
        s_rready[0] = 1'b1;
        cyc();
        s_rready[0] = 1'b0;
        check("t1_occ_after_pop", 64'(occ[0]), 64'd0);

        // 2: fill DEPTH=4, back-pressure, then drain in order
        for (int k = 0; k < 4; k++)
            push_one(0, mk(4'(k), 32'h100 + 32'(k), 2'd0, k == 3, 4'd0));
        check("t2_ready_full", 64'(m_rready[0]), 64'd0);
        check("t2_occ_full", 64'(occ[0]), 64'd4);
        check("t2_bcnt", 64'(bcnt[0]), 64'd1);
        put(0, 1'b1, mk(4'd4, 32'h104, 2'd2, 1'b1, 4'd9));
        cyc();
        check("t2_held_occ", 64'(occ[0]), 64'd4);
        s_rready[0] = 1'b1;
        check("t2_head_rid", 64'(s_rid[0]), 64'd0);
        cyc();
        check("t2_ready_reassert", 64'(m_rready[0]), 64'd1);
        check("t2_occ_after_pop", 64'(occ[0]), 64'd3);
        cyc();
        put(0, 1'b0, 64'd0);
        check("t2_occ_push_pop", 64'(occ[0]), 64'd3);
        check("t2_bcnt_push_pop", 64'(bcnt[0]), 64'd2);
        repeat (3) cyc();
        s_rready[0] = 1'b0;
        check("t2_occ_end", 64'(occ[0]), 64'd0);
        check("t2_bcnt_end", 64'(bcnt[0]), 64'd0);

        // 3: store-and-forward DEPTH=8 holds until rlast
        for (int k = 0; k < 3; k++) begin
            put(2, 1'b1, mk(4'd5, 32'h300 + 32'(k), 2'd1, k == 2, 4'(k)));
            cyc();
            put(2, 1'b0, 64'd0);
            if (k < 2) begin
                check("t3_hold_push", 64'(s_rvalid[2]), 64'd0);
                cyc();
                check("t3_hold_gap", 64'(s_rvalid[2]), 64'd0);
            end
        end
        check("t3_release", 64'(s_rvalid[2]), 64'd1);
        check("t3_occ", 64'(occ[2]), 64'd3);
        check("t3_bcnt", 64'(bcnt[2]), 64'd1);
        s_rready[2] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check("t3_b2b_valid", 64'(s_rvalid[2]), 64'd1);
            cyc();
        end
        s_rready[2] = 1'b0;
        check("t3_occ_end", 64'(occ[2]), 64'd0);
        check("t3_valid_end", 64'(s_rvalid[2]), 64'd0);

        // 4: burst longer than DEPTH=4 forces forwarding
        for (int k = 0; k < 4; k++) push_one(1, mk(4'd7, 32'h400 + 32'(k), 2'd0, 1'b0, 4'd1));
        check("t4_full_valid", 64'(s_rvalid[1]), 64'd1);
        check("t4_full_occ", 64'(occ[1]), 64'd4);
        check("t4_full_bcnt", 64'(bcnt[1]), 64'd0);
        s_rready[1] = 1'b1;
        push_one(1, mk(4'd7, 32'h404, 2'd0, 1'b0, 4'd1));
        push_one(1, mk(4'd7, 32'h405, 2'd0, 1'b1, 4'd1));
        wait_drain(1);
        check("t4_pops6", 64'(pops[1]), 64'd6);
        push_one(1, mk(4'd2, 32'h410, 2'd0, 1'b0, 4'd2));
        check("t4_reheld", 64'(s_rvalid[1]), 64'd0);
        push_one(1, mk(4'd2, 32'h411, 2'd3, 1'b1, 4'd2));
        check("t4_rel2", 64'(s_rvalid[1]), 64'd1);
        wait_drain(1);
        s_rready[1] = 1'b0;
        check("t4_pops8", 64'(pops[1]), 64'd8);
        check("t4_bcnt_end", 64'(bcnt[1]), 64'd0);

        // 5: random traffic, multiple wraps
        run_random(3, 100);
        run_random(4, 100);

        // 6: asynchronous reset mid-burst
        for (int k = 0; k < 3; k++) push_one(0, mk(4'd6, 32'h600 + 32'(k), 2'd0, 1'b0, 4'd0));
        check("t6_occ3", 64'(occ[0]), 64'd3);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 64'(s_rvalid[0]), 64'd0);
        check("t6_rst_ready", 64'(m_rready[0]), 64'd0);
        check("t6_rst_occ", 64'(occ[0]), 64'd0);
        check("t6_rst_bcnt", 64'(bcnt[0]), 64'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        #1 check("t6_rel_ready_low", 64'(m_rready[0]), 64'd0);
        cyc();
        check("t6_rel_ready_high", 64'(m_rready[0]), 64'd1);
        check("t6_rel_occ", 64'(occ[0]), 64'd0);
        check("t6_rel_valid", 64'(s_rvalid[0]), 64'd0);
        cyc();
        check("t6_no_stale", 64'(s_rvalid[0]), 64'd0);

        for (int i = 0; i < N; i++) check("sb_empty", 64'(exp_q[i].size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/axi4_r_buffer_sf.md
Name: axi4_r_buffer_sf

Overview:
Parametrised successor of the single-stage AXI4 R-channel buffer in the RAB datapath. It sits between the downstream slave's read-data channel (m_axi4_r*, input side) and the upstream master (s_axi4_r*, output side). Depth is configurable. An optional store-and-forward mode holds each burst until its RLAST beat is buffered. Occupancy and complete-burst count are exported to RAB control.

Parameters:
AXI_DATA_WIDTH, 32, RDATA width in bits
AXI_ID_WIDTH, 4, RID width
AXI_USER_WIDTH, 4, RUSER width
DEPTH, 4, entry count; power of two, >= 2
STORE_FWD, 0, 0 = cut-through, 1 = store-and-forward per burst

Ports:
axi4_aclk  in  1  clock
axi4_arstn  in  1  asynchronous active-low reset
m_axi4_rid  in  AXI_ID_WIDTH  incoming RID
m_axi4_rdata  in  AXI_DATA_WIDTH  incoming RDATA
m_axi4_rresp  in  2  incoming RRESP
m_axi4_rlast  in  1  incoming RLAST
m_axi4_ruser  in  AXI_USER_WIDTH  incoming RUSER
m_axi4_rvalid  in  1  incoming valid
m_axi4_rready  out  1  buffer can accept a beat
s_axi4_rid  out  AXI_ID_WIDTH  buffered RID
s_axi4_rdata  out  AXI_DATA_WIDTH  buffered RDATA
s_axi4_rresp  out  2  buffered RRESP
s_axi4_rlast  out  1  buffered RLAST
s_axi4_ruser  out  AXI_USER_WIDTH  buffered RUSER
s_axi4_rvalid  out  1  head beat presentable
s_axi4_rready  in  1  upstream accepts
occupancy  out  $clog2(DEPTH)+1  stored beats, 0..DEPTH
burst_cnt  out  $clog2(DEPTH)+1  stored beats with RLAST=1

Behaviour:
- Reset, asynchronous on axi4_arstn low: wr/rd pointers, occupancy and burst_cnt all 0.
  - s_axi4_rvalid = 0; m_axi4_rready = 0.
  - rdy_en_q resets to 0 and sets to 1 on the first clock edge after release.
  - Reset mid-burst drops all stored beats; no beat is presented after reset.
- Storage: DEPTH entries, each packed {ruser, rdata, rid, rlast, rresp}.
  - rresp at [1:0], rlast at [2], rid from bit 3 upward, then rdata, then ruser.
  - Pointers are $clog2(DEPTH)+1 bits including a wrap bit.
  - full = index equal and wrap bit differs; empty = pointers equal.
- Push: m_axi4_rvalid & m_axi4_rready.
  - m_axi4_rready = rdy_en_q & ~full; it is a registered-state function and never depends on s_axi4_rready.
  - No bypass when full.
- Pop: s_axi4_rvalid & s_axi4_rready. Output fields are driven combinationally from the head entry.
- Latency: a beat pushed in cycle N is visible at s_axi4_r* with s_axi4_rvalid=1 in cycle N+1 at the earliest. There is no combinational in-to-out path.
- Cut-through (STORE_FWD=0): s_axi4_rvalid = ~empty.
- Store-and-forward (STORE_FWD=1):
  - s_axi4_rvalid = ~empty & (burst_cnt != 0 | full | fwd_q).
  - Anti-deadlock rule: when full with burst_cnt==0 (burst longer than DEPTH), set fwd_q.
  - While fwd_q is set, the buffer forwards as cut-through.
  - fwd_q clears when a beat with rlast=1 is popped.
- Counters:
  - occupancy += push - pop.
  - burst_cnt += (push & m_axi4_rlast) - (pop & s_axi4_rlast).
  - Simultaneous push and pop leave each counter unchanged when the increment and decrement match.
- Wrap-around: pointer index wraps DEPTH-1 -> 0 and the wrap bit toggles. Verify at least 3 full wraps.
- Handshake rules:
  - Once s_axi4_rvalid is asserted, it stays high with stable payload until popped; the store-and-forward gating can only raise it.
  - Beat order is strictly preserved; no ID reordering.
- Illegal DEPTH (not a power of two, or < 2): elaboration-time error.

Decomposition:
- Shared package axi_rab_pkg (extend):
  - localparam field offsets R_RESP_LSB=0, R_LAST_BIT=2, R_ID_LSB=3.
  - Function r_beat_width(id, data, user) = id+data+user+3.
- Sub-module axi_fifo_rab: generic DATA_WIDTH/DEPTH FIFO.
  - Contains storage, pointers, full/empty and occupancy.
  - axi4_r_buffer_sf adds rlast tracking, burst_cnt, fwd_q, rdy_en_q and the pack/unpack logic.

Test Plan:
1. Reset, then DEPTH=4 cut-through; push one beat (rid=3, rdata=0xA5A5A5A5, rresp=0, rlast=1) with s_axi4_rready=0 -> next cycle s_axi4_rvalid=1, fields match, occupancy=1, burst_cnt=1.
2. DEPTH=4, s_axi4_rready=0; push 4 beats -> m_axi4_rready=0 after the 4th, occupancy=4, 5th beat held. Then s_axi4_rready=1 -> beats emerge in order, m_axi4_rready reasserts the cycle after the first pop.
3. STORE_FWD=1, DEPTH=8; push a 3-beat burst at one beat per 2 cycles -> s_axi4_rvalid stays 0 until the cycle after the rlast push, then 3 beats pop back-to-back.
4. STORE_FWD=1, DEPTH=4; 6-beat burst -> once full with burst_cnt=0, s_axi4_rvalid=1 and all 6 beats pass. fwd_q clears after the rlast pop; the next 2-beat burst is held until its rlast.
5. Continuous push+pop with random valid/ready for 100 beats at DEPTH=2 and DEPTH=16 -> scoreboard exact order, occupancy never >DEPTH, counters return to 0.
6. Assert axi4_arstn=0 asynchronously with occupancy=3 mid-burst -> s_axi4_rvalid=0 and m_axi4_rready=0 immediately. After release, m_axi4_rready=1 one edge later, occupancy=0, no stale beat presented.
